// File: rtl/sprite_attr_loader.sv
// Frame refresh sequencer: copies eight attribute bytes from memory into the sprite
// register file, and shares the register-file write port with a CPU requester.
module sprite_attr_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          TIMEOUT   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    input  logic              cpu_wr,
    input  logic [2:0]        cpu_sel,
    input  logic [7:0]        cpu_data,
    output logic              cpu_ready,
    output logic              Load,
    output logic [2:0]        select,
    output logic [7:0]        Data_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] idx;
    logic [7:0] tcnt;
    logic [7:0] dbuf;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            idx     <= 3'd0;
            tcnt    <= 8'd0;
            dbuf    <= 8'd0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        idx  <= 3'd0;
                        tcnt <= 8'd0;
                        err  <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        dbuf <= mem_rdata;
                    end else if (tcnt == TLAST) begin
                        dbuf <= 8'h00;
                        err  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                WRITE: begin
                    if (idx != 3'd7) begin
                        idx  <= idx + 3'd1;
                        tcnt <= 8'd0;
                    end
                end
                default: begin
                end
            endcase
            // A refresh already in flight is never restarted; the extra pulse is only recorded.
            if (frame_start && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (frame_start) state_next = REQ;
            REQ:   if (mem_ack || tcnt == TLAST) state_next = WRITE;
            WRITE: state_next = (idx == 3'd7) ? DONE : REQ;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are gated by Reset so nothing leaks onto the buses while reset is held.
    always_comb begin
        mem_req   = Reset && (state == REQ);
        mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
        cpu_ready = Reset && (state != WRITE);
        busy      = Reset && (state != IDLE);
        done      = Reset && (state == DONE);
        Load      = 1'b0;
        select    = 3'd0;
        Data_in   = 8'd0;
        if (Reset) begin
            if (state == WRITE) begin
                Load    = 1'b1;
                select  = idx;
                Data_in = dbuf;
            end else if (cpu_wr) begin
                Load    = 1'b1;
                select  = cpu_sel;
                Data_in = cpu_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_attr_loader.sv
// Directed bench for sprite_attr_loader: a behavioural attribute memory with per-sprite
// ack latency, a per-cycle output log, and hand-computed expectations.
module tb_sprite_attr_loader;

    localparam int LOGN = 48;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       cpu_wr = 1'b0;
    logic [2:0] cpu_sel = 3'd0;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_ready;
    logic       Load;
    logic [2:0] select;
    logic [7:0] Data_in;
    logic       busy;
    logic       done;
    logic       err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    int delay_tab[8];
    int age = 0;

    int   cyc = 0;
    bit   logging = 1'b0;
    logic       lg_load[LOGN];
    logic [2:0] lg_sel[LOGN];
    logic [7:0] lg_dat[LOGN];
    logic [7:0] lg_addr[LOGN];
    logic       lg_ready[LOGN];
    logic       lg_req[LOGN];
    logic       lg_busy[LOGN];
    logic       lg_done[LOGN];
    logic       lg_err[LOGN];
    logic       lg_ovr[LOGN];

    sprite_attr_loader #(
        .ADDR_W   (8),
        .BASE_ADDR(32'h40),
        .TIMEOUT  (16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .cpu_wr     (cpu_wr),
        .cpu_sel    (cpu_sel),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .Load       (Load),
        .select     (select),
        .Data_in    (Data_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    // Memory answers after delay_tab[slot] REQ cycles; a negative delay never answers.
    always @(negedge Clk) begin
        if (!mem_req) begin
            age     = 0;
            mem_ack = 1'b0;
        end else begin
            mem_ack   = (delay_tab[mem_addr[2:0]] >= 0) && (age == delay_tab[mem_addr[2:0]]);
            mem_rdata = 8'h10 + (mem_addr - 8'h40);
            age++;
        end
    end

    always begin
        @(negedge Clk);
        #1;
        if (logging && cyc < LOGN - 1) begin
            cyc++;
            lg_load[cyc]  = Load;
            lg_sel[cyc]   = select;
            lg_dat[cyc]   = Data_in;
            lg_addr[cyc]  = mem_addr;
            lg_ready[cyc] = cpu_ready;
            lg_req[cyc]   = mem_req;
            lg_busy[cyc]  = busy;
            lg_done[cyc]  = done;
            lg_err[cyc]   = err;
            lg_ovr[cyc]   = overrun;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        cyc = 0;
        for (int i = 0; i < LOGN; i++) begin
            lg_load[i] = 1'b0; lg_sel[i] = 3'd0; lg_dat[i] = 8'd0; lg_addr[i] = 8'd0;
            lg_ready[i] = 1'b0; lg_req[i] = 1'b0; lg_busy[i] = 1'b0; lg_done[i] = 1'b0;
            lg_err[i] = 1'b0; lg_ovr[i] = 1'b0;
        end
    endtask

    // Pulses frame_start (sampled at edge 0) and logs cycles 1..ncyc; optional extra
    // frame_start, CPU write (held two cycles) and reset are placed in given cycles.
    task automatic applyStimulus(input int ncyc, input int fs2_cyc, input int cpu_cyc, input int rst_cyc);
        @(negedge Clk);
        frame_start = 1'b1;
        clearLog();
        @(negedge Clk);
        frame_start = 1'b0;
        logging = 1'b1;
        for (int c = 2; c <= ncyc; c++) begin
            @(negedge Clk);
            frame_start = (c == fs2_cyc);
            Reset = (c != rst_cyc);
            if (c == cpu_cyc) begin
                cpu_wr = 1'b1; cpu_sel = 3'd3; cpu_data = 8'hAB;
            end else if (c == cpu_cyc + 2) begin
                cpu_wr = 1'b0;
            end
        end
        #2;
        logging = 1'b0;
        cpu_wr = 1'b0;
        frame_start = 1'b0;
        Reset = 1'b1;
    endtask

    function automatic int countLoads(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (lg_load[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int countBusy(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (lg_busy[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int countReq(input logic [7:0] addr, input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (lg_req[c] === 1'b1 && lg_addr[c] == addr) n++;
        return n;
    endfunction

    function automatic int firstDone(input int a, input int b);
        for (int c = a; c <= b; c++) if (lg_done[c] === 1'b1) return c;
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) delay_tab[i] = 0;

        Reset = 1'b0; cpu_wr = 1'b1; cpu_sel = 3'd2; cpu_data = 8'h77;
        repeat (2) @(negedge Clk);
        #1;
        checkOutput("rst_ready", cpu_ready, 0);
        checkOutput("rst_load", Load, 0);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_ovr", overrun, 0);
        @(negedge Clk);
        Reset = 1'b1; cpu_wr = 1'b0;

        @(negedge Clk);
        cpu_wr = 1'b1; cpu_sel = 3'd5; cpu_data = 8'h5A;
        #1;
        checkOutput("idle_ready", cpu_ready, 1);
        checkOutput("idle_load", Load, 1);
        checkOutput("idle_sel", select, 5);
        checkOutput("idle_dat", Data_in, 8'h5A);
        cpu_wr = 1'b0;
        #1;
        checkOutput("idle_noload", Load, 0);
        checkOutput("idle_nosel", select, 0);

        // Zero-wait refresh
        applyStimulus(20, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("zw_load", lg_load[2 + 2 * i], 1);
            checkOutput("zw_sel", lg_sel[2 + 2 * i], i);
            checkOutput("zw_dat", lg_dat[2 + 2 * i], 8'h10 + i);
        end
        checkOutput("zw_nloads", countLoads(1, 20), 8);
        checkOutput("zw_done", firstDone(1, 20), 17);
        checkOutput("zw_busy", countBusy(1, 20), 17);
        checkOutput("zw_addr0", lg_addr[1], 8'h40);
        checkOutput("zw_addr7", lg_addr[15], 8'h47);
        checkOutput("zw_err", lg_err[17], 0);
        checkOutput("zw_idle", lg_busy[18], 0);

        // Sprite 2 acked three cycles late
        delay_tab[2] = 3;
        applyStimulus(24, 0, 0, 0);
        checkOutput("lat_req42", countReq(8'h42, 1, 24), 4);
        checkOutput("lat_done", firstDone(1, 24), 20);
        checkOutput("lat_load2", lg_load[9], 1);
        checkOutput("lat_sel2", lg_sel[9], 2);
        checkOutput("lat_dat2", lg_dat[9], 8'h12);
        checkOutput("lat_sel7", lg_sel[19], 7);
        checkOutput("lat_dat7", lg_dat[19], 8'h17);
        checkOutput("lat_nloads", countLoads(1, 24), 8);
        delay_tab[2] = 0;

        // Sprite 5 never acked
        delay_tab[5] = -1;
        applyStimulus(40, 0, 0, 0);
        checkOutput("to_req45", countReq(8'h45, 1, 40), 16);
        checkOutput("to_req_last", lg_req[26], 1);
        checkOutput("to_req_end", lg_req[27], 0);
        checkOutput("to_load5", lg_load[27], 1);
        checkOutput("to_sel5", lg_sel[27], 5);
        checkOutput("to_dat5", lg_dat[27], 8'h00);
        checkOutput("to_err_pre", lg_err[26], 0);
        checkOutput("to_err_set", lg_err[27], 1);
        checkOutput("to_dat6", lg_dat[29], 8'h16);
        checkOutput("to_done", firstDone(1, 40), 32);
        checkOutput("to_err_held", err, 1);
        delay_tab[5] = 0;

        // CPU held across a sequencer WRITE cycle
        applyStimulus(20, 0, 4, 0);
        checkOutput("cpu_err_clr", lg_err[1], 0);
        checkOutput("cpu_ready_w", lg_ready[4], 0);
        checkOutput("cpu_sel_w", lg_sel[4], 1);
        checkOutput("cpu_dat_w", lg_dat[4], 8'h11);
        checkOutput("cpu_ready_r", lg_ready[5], 1);
        checkOutput("cpu_load_r", lg_load[5], 1);
        checkOutput("cpu_sel_r", lg_sel[5], 3);
        checkOutput("cpu_dat_r", lg_dat[5], 8'hAB);
        checkOutput("cpu_nloads", countLoads(1, 20), 9);
        checkOutput("cpu_done", firstDone(1, 20), 17);

        // Second frame_start in cycle 9
        applyStimulus(20, 9, 0, 0);
        checkOutput("ovr_pre", lg_ovr[9], 0);
        checkOutput("ovr_set", lg_ovr[10], 1);
        checkOutput("ovr_done", firstDone(1, 20), 17);
        checkOutput("ovr_nloads", countLoads(1, 20), 8);
        checkOutput("ovr_idle", lg_busy[18], 0);
        checkOutput("ovr_held", lg_ovr[20], 1);

        // Reset asserted in cycle 7
        applyStimulus(24, 0, 0, 7);
        checkOutput("mrst_load6", lg_load[6], 1);
        checkOutput("mrst_busy7", lg_busy[7], 0);
        checkOutput("mrst_busy8", lg_busy[8], 0);
        checkOutput("mrst_req8", lg_req[8], 0);
        checkOutput("mrst_nloads", countLoads(7, 24), 0);
        checkOutput("mrst_done", firstDone(1, 24), -1);
        checkOutput("mrst_ovr", lg_ovr[8], 0);

        applyStimulus(20, 0, 0, 0);
        checkOutput("rs_req1", lg_req[1], 1);
        checkOutput("rs_addr1", lg_addr[1], 8'h40);
        checkOutput("rs_load2", lg_load[2], 1);
        checkOutput("rs_sel2", lg_sel[2], 0);
        checkOutput("rs_dat2", lg_dat[2], 8'h10);
        checkOutput("rs_done", firstDone(1, 20), 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
